// File: rtl/traffic_phase_controller_if.sv
// Bundle between the phase sequencer and its environment: tick/enable/pedestrian
// controls, the duration lookup, and the light/timer/status outputs.
`timescale 1ns/1ps
interface traffic_phase_controller_if #(
  parameter int TW = 5
);
  logic          tick_1hz;
  logic          enable;
  logic          ped_req;
  logic [TW-1:0] fintime;
  logic [2:0]    state;
  logic [TW-1:0] remaining;
  logic          phase_done;
  logic          ped_wait;
  logic          err;

  modport master (
    output tick_1hz, enable, ped_req, fintime,
    input  state, remaining, phase_done, ped_wait, err
  );

  modport slave (
    input  tick_1hz, enable, ped_req, fintime,
    output state, remaining, phase_done, ped_wait, err
  );
endinterface

// File: rtl/traffic_phase_controller.sv
// RED -> GREEN -> YELLOW phase sequencer: loads each phase duration from the
// lookup, counts it down on the 1 Hz tick, and honours latched pedestrian requests.
`timescale 1ns/1ps
module traffic_phase_controller #(
  parameter int PED_MIN = 5,
  parameter int TW      = 5
) (
  input logic                     clk,
  input logic                     rst_n,
  traffic_phase_controller_if.slave bus
);
  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b100;

  localparam logic [TW-1:0] PED_REM = TW'(PED_MIN);
  localparam logic [TW-1:0] ONE     = TW'(1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] remaining_q, remaining_d;
  logic          load_pend_q, load_pend_d;
  logic          ped_wait_q, ped_wait_d;
  logic          err_q, err_d;
  logic          phase_done_q, phase_done_d;

  logic [2:0]    next_phase;
  logic          state_valid;

  always_comb begin
    next_phase = RED;
    case (state_q)
      RED:     next_phase = GREEN;
      GREEN:   next_phase = YELLOW;
      default: next_phase = RED;
    endcase
  end

  assign state_valid = (state_q == RED) || (state_q == GREEN) || (state_q == YELLOW);

  // ped_wait and phase_done are the only registers that move while disabled.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    load_pend_d  = load_pend_q;
    err_d        = err_q;
    phase_done_d = 1'b0;
    ped_wait_d   = ped_wait_q | bus.ped_req;

    if (bus.enable) begin
      if (!state_valid) begin
        state_d     = RED;
        remaining_d = '0;
        load_pend_d = 1'b1;
      end else if (load_pend_q) begin
        load_pend_d = 1'b0;
        if (bus.fintime == '0) begin
          remaining_d = ONE;
          err_d       = 1'b1;
        end else begin
          remaining_d = bus.fintime;
        end
      end else if (bus.tick_1hz) begin
        if (remaining_q <= ONE) begin
          state_d      = next_phase;
          remaining_d  = '0;
          load_pend_d  = 1'b1;
          phase_done_d = 1'b1;
          if (next_phase == RED) begin
            ped_wait_d = bus.ped_req;
          end
        end else if ((state_q == GREEN) && ped_wait_q && (remaining_q > PED_REM)) begin
          remaining_d = PED_REM;
        end else begin
          remaining_d = remaining_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RED;
      remaining_q  <= '0;
      load_pend_q  <= 1'b1;
      ped_wait_q   <= 1'b0;
      err_q        <= 1'b0;
      phase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      load_pend_q  <= load_pend_d;
      ped_wait_q   <= ped_wait_d;
      err_q        <= err_d;
      phase_done_q <= phase_done_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.remaining  = remaining_q;
  assign bus.phase_done = phase_done_q;
  assign bus.ped_wait   = ped_wait_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: directed vector table, reset corner case,
// then randomized run, all checked cycle by cycle against a phase-level model.
`timescale 1ns/1ps
module tb_traffic_phase_controller;
  localparam int TW      = 5;
  localparam int PED_MIN = 5;

  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b100;

  logic clk;
  logic rst_n;
  logic forceZeroGreen;

  traffic_phase_controller_if #(.TW(TW)) bus ();

  traffic_phase_controller #(.PED_MIN(PED_MIN), .TW(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Duration lookup seen by the DUT.
  always_comb begin
    case (bus.state)
      RED:     bus.fintime = TW'(10);
      YELLOW:  bus.fintime = TW'(20);
      GREEN:   bus.fintime = forceZeroGreen ? TW'(0) : TW'(25);
      default: bus.fintime = TW'(0);
    endcase
  end

  int compared;
  int mismatched;
  int donesSeen;

  // Reference model: phase index 0=RED, 1=GREEN, 2=YELLOW in service order.
  logic [2:0] phaseCode [3];
  int  phaseDur [3];
  int  mPhase;
  int  mRem;
  bit  mLoadPend;
  bit  mPedWait;
  bit  mErr;
  bit  mDone;

  task automatic modelReset();
    mPhase    = 0;
    mRem      = 0;
    mLoadPend = 1'b1;
    mPedWait  = 1'b0;
    mErr      = 1'b0;
    mDone     = 1'b0;
  endtask

  task automatic modelStep(input bit tk, input bit en, input bit pd);
    int dur;
    bit nextPw;
    nextPw = mPedWait | pd;
    mDone  = 1'b0;
    if (en) begin
      if (mLoadPend) begin
        dur = (mPhase == 1 && forceZeroGreen) ? 0 : phaseDur[mPhase];
        if (dur == 0) begin
          mErr = 1'b1;
          dur  = 1;
        end
        mRem      = dur;
        mLoadPend = 1'b0;
      end else if (tk) begin
        if (mRem == 1) begin
          mPhase    = (mPhase + 1) % 3;
          mRem      = 0;
          mLoadPend = 1'b1;
          mDone     = 1'b1;
          if (mPhase == 0) nextPw = pd;
        end else if (mPhase == 1 && mPedWait && mRem > PED_MIN) begin
          mRem = PED_MIN;
        end else begin
          mRem = mRem - 1;
        end
      end
    end
    mPedWait = nextPw;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAgainstModel();
    checkOutput("model.state",      int'(bus.state),      int'(phaseCode[mPhase]));
    checkOutput("model.remaining",  int'(bus.remaining),  mRem);
    checkOutput("model.phase_done", int'(bus.phase_done), int'(mDone));
    checkOutput("model.ped_wait",   int'(bus.ped_wait),   int'(mPedWait));
    checkOutput("model.err",        int'(bus.err),        int'(mErr));
  endtask

  task automatic stepCycle(input bit tk, input bit en, input bit pd);
    bus.tick_1hz = tk;
    bus.enable   = en;
    bus.ped_req  = pd;
    modelStep(tk, en, pd);
    @(posedge clk);
    #1;
    if (bus.phase_done) donesSeen++;
    checkAgainstModel();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".state"},      int'(bus.state),      int'(RED));
    checkOutput({tag, ".remaining"},  int'(bus.remaining),  0);
    checkOutput({tag, ".phase_done"}, int'(bus.phase_done), 0);
    checkOutput({tag, ".ped_wait"},   int'(bus.ped_wait),   0);
    checkOutput({tag, ".err"},        int'(bus.err),        0);
  endtask

  typedef struct {
    int         nTicks;
    bit         en;
    bit         ped;
    bit         zero;
    logic [2:0] expState;
    int         expRem;
    bit         expPw;
    bit         expErr;
    int         expDones;
  } vecT;

  localparam int NVEC = 25;
  vecT vecs [NVEC];

  task automatic applyStimulus(input vecT v);
    forceZeroGreen = v.zero;
    if (v.ped) stepCycle(1'b0, v.en, 1'b1);
    for (int t = 0; t < v.nTicks; t++) begin
      stepCycle(1'b1, v.en, 1'b0);
      stepCycle(1'b0, v.en, 1'b0);
    end
  endtask

  initial begin
    int startDones;
    string tag;

    phaseCode[0] = RED;    phaseDur[0] = 10;
    phaseCode[1] = GREEN;  phaseDur[1] = 25;
    phaseCode[2] = YELLOW; phaseDur[2] = 20;

    //           ticks en ped zero state   rem pw err dones
    vecs[0]  = '{ 9, 1, 0, 0, RED,     1, 0, 0, 0};
    vecs[1]  = '{ 1, 1, 0, 0, GREEN,  25, 0, 0, 1};
    vecs[2]  = '{ 5, 1, 0, 0, GREEN,  20, 0, 0, 0};
    vecs[3]  = '{ 1, 1, 1, 0, GREEN,   5, 1, 0, 0};
    vecs[4]  = '{ 4, 1, 0, 0, GREEN,   1, 1, 0, 0};
    vecs[5]  = '{ 1, 1, 0, 0, YELLOW, 20, 1, 0, 1};
    vecs[6]  = '{20, 1, 0, 0, RED,    10, 0, 0, 1};
    vecs[7]  = '{ 4, 1, 0, 0, RED,     6, 0, 0, 0};
    vecs[8]  = '{ 7, 0, 1, 0, RED,     6, 1, 0, 0};
    vecs[9]  = '{ 5, 1, 0, 0, RED,     1, 1, 0, 0};
    vecs[10] = '{ 1, 1, 0, 0, GREEN,  25, 1, 0, 1};
    vecs[11] = '{ 1, 1, 0, 0, GREEN,   5, 1, 0, 0};
    vecs[12] = '{ 5, 1, 0, 0, YELLOW, 20, 1, 0, 1};
    vecs[13] = '{20, 1, 0, 0, RED,    10, 0, 0, 1};
    vecs[14] = '{10, 1, 0, 0, GREEN,  25, 0, 0, 1};
    vecs[15] = '{22, 1, 0, 0, GREEN,   3, 0, 0, 0};
    vecs[16] = '{ 2, 1, 1, 0, GREEN,   1, 1, 0, 0};
    vecs[17] = '{ 1, 1, 0, 0, YELLOW, 20, 1, 0, 1};
    vecs[18] = '{20, 1, 0, 0, RED,    10, 0, 0, 1};
    vecs[19] = '{10, 1, 0, 1, GREEN,   1, 0, 1, 1};
    vecs[20] = '{ 1, 1, 0, 0, YELLOW, 20, 0, 1, 1};
    vecs[21] = '{20, 1, 0, 0, RED,    10, 0, 1, 1};
    vecs[22] = '{10, 1, 0, 0, GREEN,  25, 0, 1, 1};
    vecs[23] = '{25, 1, 0, 0, YELLOW, 20, 0, 1, 1};
    vecs[24] = '{ 3, 1, 1, 0, YELLOW, 17, 1, 1, 0};

    compared       = 0;
    mismatched     = 0;
    donesSeen      = 0;
    forceZeroGreen = 1'b0;
    bus.tick_1hz   = 1'b0;
    bus.enable     = 1'b0;
    bus.ped_req    = 1'b0;
    rst_n          = 1'b0;
    modelReset();

    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");

    @(negedge clk);
    rst_n = 1'b1;
    stepCycle(1'b0, 1'b1, 1'b0);
    checkOutput("release.state",     int'(bus.state),     int'(RED));
    checkOutput("release.remaining", int'(bus.remaining), 10);

    for (int i = 0; i < NVEC; i++) begin
      startDones = donesSeen;
      applyStimulus(vecs[i]);
      tag = $sformatf("vec%0d", i);
      checkOutput({tag, ".state"},     int'(bus.state),     int'(vecs[i].expState));
      checkOutput({tag, ".remaining"}, int'(bus.remaining), vecs[i].expRem);
      checkOutput({tag, ".ped_wait"},  int'(bus.ped_wait),  int'(vecs[i].expPw));
      checkOutput({tag, ".err"},       int'(bus.err),       int'(vecs[i].expErr));
      checkOutput({tag, ".dones"},     donesSeen - startDones, vecs[i].expDones);
    end

    // Asynchronous reset mid-YELLOW with a pending request and err set.
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midReset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle(1'b0, 1'b1, 1'b0);
    checkOutput("restart.state",     int'(bus.state),     int'(RED));
    checkOutput("restart.remaining", int'(bus.remaining), 10);
    for (int t = 0; t < 10; t++) begin
      stepCycle(1'b1, 1'b1, 1'b0);
      stepCycle(1'b0, 1'b1, 1'b0);
    end
    checkOutput("restart.green", int'(bus.state), int'(GREEN));

    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 299) == 0) forceZeroGreen = ~forceZeroGreen;
      if ($urandom_range(0, 1499) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("randReset");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      stepCycle(($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 24) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
